// File: rtl/inst_mem_prog.sv
// Writable instruction memory for the fetch stage: registered fetch port with
// stall hold, runtime program-load port, alignment/range fault detection and
// an optional post-reset sweep that clears every word to NOP_WORD.
module inst_mem_prog #(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       ADDR_W         = 6,
    parameter logic [DATA_W-1:0] NOP_WORD       = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              stall,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              fetch_fault,
    input  logic              prog_we,
    input  logic [31:0]       prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ack,
    output logic              prog_err,
    output logic              init_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_inst_q, fetch_inst_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic              prog_ack_q, prog_ack_d;
    logic              prog_err_q, prog_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [DATA_W-1:0] mem_wdata;

    logic              run;
    logic              fetch_bad;
    logic              prog_bad;
    logic [ADDR_W-1:0] fetch_idx;
    logic [ADDR_W-1:0] prog_idx;

    // Misaligned, or any address bit above the word index set (no aliasing).
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    assign fetch_bad = addr_fault(fetch_addr);
    assign prog_bad  = addr_fault(prog_addr);
    assign fetch_idx = fetch_addr[ADDR_W+1:2];
    assign prog_idx  = prog_addr[ADDR_W+1:2];

    // init_done_q gates acceptance so that, without the clear sweep, ports
    // still open only from the first edge after reset release.
    assign run = (state_q == ST_RUN) && init_done_q;

    // State register and all resettable control/output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
            else                state_q <= ST_RUN;
            clr_cnt_q     <= '0;
            init_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= NOP_WORD;
            fetch_fault_q <= 1'b0;
            prog_ack_q    <= 1'b0;
            prog_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            init_done_q   <= init_done_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_fault_q <= fetch_fault_d;
            prog_ack_q    <= prog_ack_d;
            prog_err_q    <= prog_err_d;
        end
    end

    // Next-state logic: sweep the clear counter, then settle in RUN
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Outputs: memory write port select, fetch pipeline register, program ack
    always_comb begin
        mem_we        = 1'b0;
        mem_idx       = '0;
        mem_wdata     = NOP_WORD;
        fetch_valid_d = fetch_valid_q;
        fetch_inst_d  = fetch_inst_q;
        fetch_fault_d = fetch_fault_q;
        prog_ack_d    = 1'b0;
        prog_err_d    = 1'b0;

        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_wdata = NOP_WORD;
        end else if (run && prog_we && !prog_bad) begin
            mem_we    = 1'b1;
            mem_idx   = prog_idx;
            mem_wdata = prog_data;
        end

        if (run) begin
            prog_ack_d = prog_we;
            prog_err_d = prog_we && prog_bad;
        end

        // Read uses the pre-edge array contents, giving read-before-write.
        if (run && !stall) begin
            fetch_valid_d = fetch_req;
            if (fetch_req) begin
                fetch_fault_d = fetch_bad;
                fetch_inst_d  = fetch_bad ? NOP_WORD : mem_q[fetch_idx];
            end else begin
                fetch_fault_d = 1'b0;
            end
        end
    end

    // Storage array: single write port shared by clear sweep and program load
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    assign fetch_ready = init_done_q;
    assign init_done   = init_done_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_inst  = fetch_inst_q;
    assign fetch_fault = fetch_fault_q;
    assign prog_ack    = prog_ack_q;
    assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_inst_mem_prog.sv
// Bench for inst_mem_prog: table of fetch/program vectors plus hand-written
// sequences for stall hold, same-cycle read/write, and reset during CLEAR.
module tb_inst_mem_prog;

    logic        clk;
    logic        rst_n, rst_n1;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        stall;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    logic        fetch_ready, fetch_valid, fetch_fault, prog_ack, prog_err, init_done;
    logic [31:0] fetch_inst;
    logic        fetch_ready1, fetch_valid1, fetch_fault1, prog_ack1, prog_err1, init_done1;
    logic [31:0] fetch_inst1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
    } fexp_t;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_inst;
        logic        exp_flag;   // fetch_fault for fetches, prog_err for writes
    } vec_t;

    fexp_t fq[$];
    logic  wq[$];

    inst_mem_prog #(.DATA_W(32), .ADDR_W(6), .NOP_WORD(32'h0), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_inst(fetch_inst), .fetch_fault(fetch_fault), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack),
        .prog_err(prog_err), .init_done(init_done)
    );

    inst_mem_prog #(.DATA_W(32), .ADDR_W(6), .NOP_WORD(32'h0), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n1), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .fetch_ready(fetch_ready1), .fetch_valid(fetch_valid1),
        .fetch_inst(fetch_inst1), .fetch_fault(fetch_fault1), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack1),
        .prog_err(prog_err1), .init_done(init_done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_fetch(input string nm);
        fexp_t e;
        check_eq({nm, "_valid"}, fetch_valid, 1);
        if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected fetch queued", nm);
        end else begin
            e = fq.pop_front();
            check_eq({nm, "_inst"}, fetch_inst, e.inst);
            check_eq({nm, "_fault"}, fetch_fault, e.fault);
        end
    endtask

    task automatic pop_write(input string nm);
        logic e;
        check_eq({nm, "_ack"}, prog_ack, 1);
        if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected write queued", nm);
        end else begin
            e = wq.pop_front();
            check_eq({nm, "_err"}, prog_err, e);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_inst,
                            input logic exp_fault, input string nm);
        fetch_req  = 1'b1;
        fetch_addr = a;
        fq.push_back('{inst: exp_inst, fault: exp_fault});
        tick();
        fetch_req = 1'b0;
        pop_fetch(nm);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic exp_err, input string nm);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        wq.push_back(exp_err);
        tick();
        prog_we = 1'b0;
        pop_write(nm);
    endtask

    // Hold requests active during CLEAR, count cycles until fetch_ready.
    task automatic wait_ready(input string nm);
        int n;
        bit saw;
        n   = 0;
        saw = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        prog_we    = 1'b1;
        prog_addr  = 32'h4;
        prog_data  = 32'hFFFF_FFFF;
        while (!fetch_ready && n < 200) begin
            tick();
            n++;
            if (fetch_valid || prog_ack) saw = 1'b1;
        end
        fetch_req = 1'b0;
        prog_we   = 1'b0;
        check_eq({nm, "_clear_cycles"}, n, 64);
        check_eq({nm, "_clear_ignored"}, saw, 0);
        check_eq({nm, "_init_done"}, init_done, 1);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{0, 32'h0000_00FC, 32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{1, 32'h0000_0004, 32'h3C008043,  32'h0,         1'b0};
        vecs[3]  = '{0, 32'h0000_0004, 32'h0,         32'h3C008043,  1'b0};
        vecs[4]  = '{0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1};
        vecs[5]  = '{0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1};
        vecs[6]  = '{1, 32'h0000_0100, 32'hDEADBEEF,  32'h0,         1'b1};
        vecs[7]  = '{0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[8]  = '{1, 32'h0000_0003, 32'h1111_1111, 32'h0,         1'b1};
        vecs[9]  = '{1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[10] = '{0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[11] = '{0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[12] = '{1, 32'h0000_0008, 32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[13] = '{0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};

        rst_n = 1'b0; rst_n1 = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ready", fetch_ready, 0);
        check_eq("rst_valid", fetch_valid, 0);
        check_eq("rst_inst", fetch_inst, 32'h0);
        check_eq("rst_fault", fetch_fault, 0);
        check_eq("rst_ack", prog_ack, 0);
        check_eq("rst_err", prog_err, 0);
        check_eq("rst_init", init_done, 0);

        // No-clear variant: ready one edge after release
        rst_n1 = 1'b1;
        check_eq("nc_ready_pre", fetch_ready1, 0);
        tick();
        check_eq("nc_ready_post", fetch_ready1, 1);
        check_eq("nc_init_post", init_done1, 1);

        rst_n = 1'b1;
        wait_ready("boot");

        // Table-driven vectors
        foreach (vecs[i]) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_flag, $sformatf("vec%0d", i));
                tick();
                check_eq($sformatf("vec%0d_ack_pulse", i), prog_ack, 0);
            end else begin
                do_fetch(vecs[i].addr, vecs[i].exp_inst, vecs[i].exp_flag, $sformatf("vec%0d", i));
            end
        end

        // Idle cycle: valid and fault drop, inst holds
        tick();
        check_eq("idle_valid", fetch_valid, 0);
        check_eq("idle_inst", fetch_inst, 32'h0);

        // Stall hold
        do_fetch(32'h4, 32'h3C008043, 1'b0, "stall_pre");
        stall      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("stall%0d_valid", k), fetch_valid, 1);
            check_eq($sformatf("stall%0d_inst", k), fetch_inst, 32'h3C008043);
        end
        stall = 1'b0;
        fq.push_back('{inst: 32'h0BAD_F00D, fault: 1'b0});
        tick();
        fetch_req = 1'b0;
        pop_fetch("stall_post");

        // Same-cycle write and fetch on one word: old value first
        prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'h1234_5678;
        wq.push_back(1'b0);
        fetch_req = 1'b1; fetch_addr = 32'h10;
        fq.push_back('{inst: 32'h0, fault: 1'b0});
        tick();
        prog_we = 1'b0; fetch_req = 1'b0;
        pop_write("rbw_wr");
        pop_fetch("rbw_old");
        do_fetch(32'h10, 32'h1234_5678, 1'b0, "rbw_new");

        // Reset mid-CLEAR
        rst_n = 1'b0;
        #1;
        check_eq("rst2_valid", fetch_valid, 0);
        check_eq("rst2_ready", fetch_ready, 0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check_eq("midclr_ready", fetch_ready, 0);
        tick();
        rst_n = 1'b1;
        wait_ready("midclr");

        // Program, then reset: contents cleared again
        do_write(32'h4, 32'h3C008043, 1'b0, "pre_rst_wr");
        do_fetch(32'h4, 32'h3C008043, 1'b0, "pre_rst_rd");
        rst_n = 1'b0;
        #1;
        check_eq("rst3_valid", fetch_valid, 0);
        check_eq("rst3_inst", fetch_inst, 32'h0);
        check_eq("rst3_init", init_done, 0);
        tick();
        rst_n = 1'b1;
        wait_ready("reclr");
        do_fetch(32'h4, 32'h0, 1'b0, "reclr_w1");
        do_fetch(32'h10, 32'h0, 1'b0, "reclr_w4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
